// File: rtl/cordic_sqrt_result_buffer.sv
// cordic_sqrt_result_buffer: tagged FIFO for CORDIC sqrt results with issue credit; SQRT_RBUF_STATS_EN enables result/drop counters
module cordic_sqrt_result_buffer #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  done_in,
    input  logic [DATA_WIDTH-1:0] sqrt_in,
    output logic                  issue_ok,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  result_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_WIDTH+TAG_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n, inflight, inflight_n;
    logic [TAG_WIDTH-1:0] tag;
    logic pop, push, drop;

    assign m_valid  = count != '0;
    assign issue_ok = ({1'b0, count} + {1'b0, inflight}) < {1'b0, FULL};
    assign pop      = m_valid & m_ready;
    assign push     = done_in & ((count != FULL) | pop);
    assign drop     = done_in & ~push;
    assign rd_ptr_n = rd_ptr + AW'(pop);

    always_comb begin
        count_n    = count + CW'(push) - CW'(pop);
        inflight_n = (start_in && !done_in && inflight != FULL) ? inflight + CW'(1) :
                     (!start_in && done_in && inflight != '0)   ? inflight - CW'(1) : inflight;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {sqrt_in, tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            tag      <= '0;
            overflow <= 1'b0;
            m_data   <= '0;
            m_tag    <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr_n;
            count    <= count_n;
            inflight <= inflight_n;
            tag      <= tag + TAG_WIDTH'(push);
            overflow <= overflow | drop;
            // head register: a fresh write lands in the head slot when the FIFO drains to it
            if (count_n != '0)
                {m_data, m_tag} <= (push && wr_ptr == rd_ptr_n) ? {sqrt_in, tag} : mem[rd_ptr_n];
        end
    end

`ifdef SQRT_RBUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (push && result_cnt != '1) result_cnt <= result_cnt + CNT_WIDTH'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign result_cnt = '0;
    assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_cordic_sqrt_result_buffer.sv
// tb_cordic_sqrt_result_buffer: scenario tasks plus randomized traffic against a queue-based model
module tb_cordic_sqrt_result_buffer;
    localparam int DW = 18;
    localparam int DEPTH = 8;
    localparam int TW = 4;
    localparam int CNTW = 16;

    logic clk = 1'b0, rst_n = 1'b0, start_in = 1'b0, done_in = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] sqrt_in = '0;
    logic issue_ok, m_valid, overflow;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    logic [CNTW-1:0] result_cnt, drop_cnt;

    int n_checks = 0, n_fail = 0;

    logic [DW+TW-1:0] q[$];
    int inflight, results, drops;
    logic ovf;
    logic [TW-1:0] tag;
    logic [DW-1:0] hd_data;
    logic [TW-1:0] hd_tag;

    cordic_sqrt_result_buffer dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .done_in(done_in), .sqrt_in(sqrt_in),
        .issue_ok(issue_ok), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
        .overflow(overflow), .result_cnt(result_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        inflight = 0; results = 0; drops = 0; ovf = 1'b0; tag = '0; hd_data = '0; hd_tag = '0;
    endtask

    function automatic logic exp_ok();
        return (q.size() + inflight) < DEPTH;
    endfunction

    function automatic logic [CNTW-1:0] exp_res();
`ifdef SQRT_RBUF_STATS_EN
        return CNTW'(results > 65535 ? 65535 : results);
`else
        return '0;
`endif
    endfunction

    function automatic logic [CNTW-1:0] exp_drop();
`ifdef SQRT_RBUF_STATS_EN
        return CNTW'(drops > 65535 ? 65535 : drops);
`else
        return '0;
`endif
    endfunction

    task automatic tick(input logic s, input logic d, input logic [DW-1:0] x, input logic r);
        start_in = s; done_in = d; sqrt_in = x; m_ready = r;
        @(posedge clk);
        if (r && q.size() > 0) void'(q.pop_front());
        if (d) begin
            if (q.size() < DEPTH) begin
                q.push_back({x, tag});
                tag++;
                results++;
            end else begin
                ovf = 1'b1;
                drops++;
            end
        end
        if (s && !d) inflight = inflight < DEPTH ? inflight + 1 : DEPTH;
        if (d && !s) inflight = inflight > 0 ? inflight - 1 : 0;
        if (q.size() > 0) {hd_data, hd_tag} = q[0];
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start_in = 1'b0; done_in = 1'b0; m_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({m_valid, m_data, m_tag, issue_ok, overflow} !== {1'b0, {DW{1'b0}}, {TW{1'b0}}, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h ok=%b ovf=%b want v=0 d=0 t=0 ok=1 ovf=0",
                     m_valid, m_data, m_tag, issue_ok, overflow);
        end
        n_checks++;
        if (result_cnt !== '0 || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got res=%0d drop=%0d want 0 0", result_cnt, drop_cnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        tick(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (issue_ok !== 1'b1 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_wait[%0d]: got ok=%b v=%b want ok=1 v=0", i, issue_ok, m_valid);
            end
            if (i < 12) tick(1'b0, 1'b0, '0, 1'b0);
        end
        tick(1'b0, 1'b1, 18'h00C80, 1'b0);
        n_checks++;
        if ({m_valid, m_data, m_tag, issue_ok} !== {1'b1, 18'h00C80, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_result: got v=%b d=%h t=%h ok=%b want v=1 d=00c80 t=0 ok=1",
                     m_valid, m_data, m_tag, issue_ok);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 18'h00C80) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b d=%h want v=0 d=00c80 (held)", m_valid, m_data);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] x;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            n_checks++;
            if (issue_ok !== (i < 7)) begin
                n_fail++;
                $display("FAIL fill_issue_ok[%0d]: got %b want %b", i, issue_ok, i < 7);
            end
        end
        for (int i = 0; i < 8; i++) begin
            x = DW'($urandom);
            tick(1'b0, 1'b1, x, 1'b0);
            n_checks++;
            if (issue_ok !== 1'b0 || m_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_done[%0d]: got ok=%b v=%b want ok=0 v=1", i, issue_ok, m_valid);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m_tag !== TW'(i) || m_data !== hd_data || m_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got t=%h d=%h v=%b want t=%h d=%h v=1",
                         i, m_tag, m_data, m_valid, TW'(i), hd_data);
            end
            tick(1'b0, 1'b0, '0, 1'b1);
            n_checks++;
            if (issue_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_credit[%0d]: got %b want 1", i, issue_ok);
            end
        end
    endtask

    task automatic test_drop();
        apply_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, DW'($urandom), 1'b0);
        tick(1'b0, 1'b1, 18'h3FFFF, 1'b0);
        n_checks++;
        if ({overflow, issue_ok, m_tag} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL drop_state: got ovf=%b ok=%b t=%h want ovf=1 ok=0 t=0", overflow, issue_ok, m_tag);
        end
        n_checks++;
        if (drop_cnt !== exp_drop() || result_cnt !== exp_res()) begin
            n_fail++;
            $display("FAIL drop_counters: got drop=%0d res=%0d want %0d %0d", drop_cnt, result_cnt, exp_drop(), exp_res());
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (m_tag !== TW'(i) || m_data !== hd_data) begin
                n_fail++;
                $display("FAIL drop_drain[%0d]: got t=%h d=%h want t=%h d=%h", i, m_tag, m_data, TW'(i), hd_data);
            end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        n_checks++;
        if (m_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_sticky: got v=%b ovf=%b want v=0 ovf=1", m_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, DW'($urandom), 1'b0);
        n_checks++;
        if (m_tag !== 4'd0) begin
            n_fail++;
            $display("FAIL fpp_head: got t=%h want 0", m_tag);
        end
        tick(1'b0, 1'b1, 18'h2ABCD, 1'b1);
        n_checks++;
        if ({overflow, issue_ok, m_valid, m_tag} !== {1'b0, 1'b0, 1'b1, 4'd1} || drop_cnt !== '0) begin
            n_fail++;
            $display("FAIL fpp_state: got ovf=%b ok=%b v=%b t=%h drop=%0d want ovf=0 ok=0 v=1 t=1 drop=0",
                     overflow, issue_ok, m_valid, m_tag, drop_cnt);
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (m_tag !== TW'(i) || m_data !== hd_data) begin
                n_fail++;
                $display("FAIL fpp_drain[%0d]: got t=%h d=%h want t=%h d=%h", i, m_tag, m_data, TW'(i), hd_data);
            end
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        n_checks++;
        if (hd_data !== 18'h2ABCD || m_data !== 18'h2ABCD) begin
            n_fail++;
            $display("FAIL fpp_last: got d=%h want 2abcd", m_data);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, DW'($urandom), 1'b1);
            n_checks++;
            if (m_valid !== 1'b1 || m_tag !== TW'(i % 16) || m_data !== hd_data || issue_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got v=%b t=%h d=%h ok=%b want v=1 t=%h d=%h ok=1",
                         i, m_valid, m_tag, m_data, issue_ok, TW'(i % 16), hd_data);
            end
        end
        n_checks++;
`ifdef SQRT_RBUF_STATS_EN
        if (result_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL wrap_result_cnt: got %0d want 20", result_cnt);
        end
`else
        if (result_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_result_cnt: got %0d want 0", result_cnt);
        end
`endif
        tick(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, DW'($urandom), 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || issue_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_async: got v=%b ok=%b want v=0 ok=1", m_valid, issue_ok);
        end
        apply_reset();
        tick(1'b0, 1'b1, 18'h1F00D, 1'b0);
        n_checks++;
        if ({m_valid, m_data, m_tag, issue_ok} !== {1'b1, 18'h1F00D, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_late: got v=%b d=%h t=%h ok=%b want v=1 d=1f00d t=0 ok=1",
                     m_valid, m_data, m_tag, issue_ok);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 45) && (exp_ok() || $urandom_range(0, 9) == 0),
                 $urandom_range(0, 99) < 50, DW'($urandom), $urandom_range(0, 99) < 45);
            n_checks++;
            if ({m_valid, m_data, m_tag, issue_ok, overflow} !== {q.size() > 0, hd_data, hd_tag, exp_ok(), ovf}) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b d=%h t=%h ok=%b ovf=%b want v=%b d=%h t=%h ok=%b ovf=%b",
                         i, m_valid, m_data, m_tag, issue_ok, overflow, q.size() > 0, hd_data, hd_tag, exp_ok(), ovf);
            end
            n_checks++;
            if (result_cnt !== exp_res() || drop_cnt !== exp_drop()) begin
                n_fail++;
                $display("FAIL random_cnt[%0d]: got res=%0d drop=%0d want %0d %0d",
                         i, result_cnt, drop_cnt, exp_res(), exp_drop());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_fill();
        test_drop();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
